// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the multi-cycle CPU MEMread/MEMwrite handshake.
// Define MEM_WP_EN to write-protect words [0..PROTECT_LIMIT-1].
module mem_responder #(
    parameter int ADDR_W        = 9,
    parameter int WAIT_CYC      = 2,
    parameter int PROTECT_LIMIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MEMread,
    input  logic              MEMwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, DONE, RELEASE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERR} op_t;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

`ifdef MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    state_t            state, next_state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wait_cnt;
    logic [31:0]       ram [DEPTH];
    logic              request;
    logic              in_protect;
    logic              wp_reject;
    logic              commit_write;

    assign request      = MEMread | MEMwrite;
    assign in_protect   = {1'b0, addr_q} < (ADDR_W+1)'(PROTECT_LIMIT);
    assign wp_reject    = WP_ON && (op_q == OP_WRITE) && in_protect;
    assign commit_write = (state == ACCESS) && (op_q == OP_WRITE) && !wp_reject;
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = (WAIT_CYC == 0) ? ACCESS : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = ACCESS;
            ACCESS:  next_state = DONE;
            DONE:    next_state = RELEASE;
            // A request level still held after completion must not start a new access.
            RELEASE: if (!request) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The completion pulse and error flag are registered off the DONE state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_ready <= (state == DONE);
            err       <= (state == DONE) && ((op_q == OP_ERR) || wp_reject);
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        wait_cnt <= '0;
                        if (MEMread && MEMwrite) begin
                            op_q <= OP_ERR;
                        end else if (MEMwrite) begin
                            op_q <= OP_WRITE;
                        end else begin
                            op_q <= OP_READ;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                ACCESS: begin
                    if (op_q == OP_READ) begin
                        rdata <= ram[addr_q];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM contents survive reset; only a write reaching ACCESS is committed.
    always_ff @(posedge clock) begin
        if (commit_write) begin
            ram[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: DUT 0 uses WAIT_CYC=2, DUT 1 uses WAIT_CYC=0.
module tb_mem_responder;

    localparam int ADDR_W = 9;

`ifdef MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    typedef struct {
        int          dut;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       mem_read  = '0;
    logic [1:0]       mem_write = '0;
    logic [1:0][31:0] mar   = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][31:0] rdata;
    logic [1:0]       mem_ready;
    logic [1:0]       busy;
    logic [1:0]       err;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(2), .PROTECT_LIMIT(16)) dut0 (
        .clock(clock), .reset(reset),
        .MEMread(mem_read[0]), .MEMwrite(mem_write[0]),
        .addr(mar[0][ADDR_W-1:0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .mem_ready(mem_ready[0]), .busy(busy[0]), .err(err[0])
    );

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(0), .PROTECT_LIMIT(16)) dut1 (
        .clock(clock), .reset(reset),
        .MEMread(mem_read[1]), .MEMwrite(mem_write[1]),
        .addr(mar[1][ADDR_W-1:0]), .wdata(wdata[1]),
        .rdata(rdata[1]), .mem_ready(mem_ready[1]), .busy(busy[1]), .err(err[1])
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, need 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every mem_ready pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ready[d]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_pulse dut%0d: got mem_ready=1, need 0 (cycle %0d)", d, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput($sformatf("dut_id dut%0d", d), d, e.dut);
                    checkOutput($sformatf("latency dut%0d", d), cyc, e.exp_cyc);
                    checkOutput($sformatf("err dut%0d", d), {31'b0, err[d]}, {31'b0, e.exp_err});
                    if (e.chk_rd) begin
                        checkOutput($sformatf("rdata dut%0d", d), rdata[d], e.exp_rd);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input bit rd, input bit wr,
                                 input logic [31:0] m, input logic [31:0] data,
                                 input bit exp_err, input bit chk_rd,
                                 input logic [31:0] exp_rd, input int hold);
        exp_t e;
        bit   seen;
        @(negedge clock);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        mar[d]       = m;
        wdata[d]     = data;
        e.dut     = d;
        e.exp_err = exp_err;
        e.chk_rd  = chk_rd;
        e.exp_rd  = exp_rd;
        e.exp_cyc = cyc + waitOf(d) + 3;
        sbq.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            seen = mem_ready[d];
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL timeout dut%0d addr 0x%08h: got no mem_ready, need one", d, m);
            sbq.delete();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("hold_busy", {31'b0, busy[d]}, 32'd1);
            checkOutput("hold_ready", {31'b0, mem_ready[d]}, 32'd0);
        end
        checkOutput("busy_before_release", {31'b0, busy[d]}, 32'd1);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        @(negedge clock);
        checkOutput("busy_after_release", {31'b0, busy[d]}, 32'd0);
    endtask

    task automatic checkResetOutputs(input int d);
        checkOutput($sformatf("reset_rdata dut%0d", d), rdata[d], 32'h0);
        checkOutput($sformatf("reset_ready dut%0d", d), {31'b0, mem_ready[d]}, 32'd0);
        checkOutput($sformatf("reset_busy dut%0d", d), {31'b0, busy[d]}, 32'd0);
        checkOutput($sformatf("reset_err dut%0d", d), {31'b0, err[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, need finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        #2;
        checkResetOutputs(0);
        checkResetOutputs(1);
        @(negedge clock);
        reset = 1'b1;

        // Reset abandons a write that is still waiting.
        applyStimulus(0, 0, 1, 32'h020, 32'h11111111, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h020, 32'h0, 0, 1, 32'h11111111, 0);
        @(negedge clock);
        mem_write[0] = 1'b1;
        mar[0]       = 32'h020;
        wdata[0]     = 32'hDEADBEEF;
        @(negedge clock);
        checkOutput("busy_in_wait", {31'b0, busy[0]}, 32'd1);
        reset = 1'b0;
        #1;
        checkResetOutputs(0);
        mem_write[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(0, 1, 0, 32'h020, 32'h0, 0, 1, 32'h11111111, 0);

        // Write then read back, then a request level held for ten cycles.
        applyStimulus(0, 0, 1, 32'h0A5, 32'h12345678, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0A5, 32'h0, 0, 1, 32'h12345678, 0);
        applyStimulus(0, 1, 0, 32'h0A5, 32'h0, 0, 1, 32'h12345678, 5);

        // Both request lines high: rejected, RAM and rdata untouched.
        applyStimulus(0, 0, 1, 32'h010, 32'hCAFEF00D, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0A5, 32'h0, 0, 1, 32'h12345678, 0);
        applyStimulus(0, 1, 1, 32'h010, 32'h0BADBAD0, 1, 1, 32'h12345678, 0);
        applyStimulus(0, 1, 0, 32'h010, 32'h0, 0, 1, 32'hCAFEF00D, 0);

        // Protection boundary at word 16.
        applyStimulus(0, 0, 1, 32'h00F, 32'hFFFFFFFF, WP_ON, 0, 32'h0, 0);
`ifndef MEM_WP_EN
        applyStimulus(0, 1, 0, 32'h00F, 32'h0, 0, 1, 32'hFFFFFFFF, 0);
`endif
        applyStimulus(0, 0, 1, 32'h010, 32'hFFFFFFFF, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h010, 32'h0, 0, 1, 32'hFFFFFFFF, 0);

        // Upper MAR bits are dropped; zero wait states on DUT 1.
        applyStimulus(0, 0, 1, 32'h3FF, 32'h5A5A0002, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h1FF, 32'h0, 0, 1, 32'h5A5A0002, 0);
        applyStimulus(1, 0, 1, 32'h3FF, 32'hA5A50001, 0, 0, 32'h0, 0);
        applyStimulus(1, 1, 0, 32'h1FF, 32'h0, 0, 1, 32'hA5A50001, 0);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
